// File: rtl/cordic_sqrt_pipe.sv
// cordic_sqrt_pipe: fully pipelined hyperbolic-CORDIC square root, one result per advancing cycle.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        operand handshake (in_ready = global advance)
//   in_data, in_tag          unsigned Q(DATA_W-FRAC_W).FRAC_W operand and its sideband tag
//   out_valid/out_ready      result handshake
//   out_data, out_tag        round(sqrt(in_data)) in the same Q format, tag of that operand
//   out_zero                 operand was zero
module cordic_sqrt_pipe #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16,
    parameter int ITER   = 20,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_zero
);
    localparam int R   = int'(ITER >= 4) + int'(ITER >= 13) + int'(ITER >= 40);
    localparam int NST = ITER + R;
    localparam int IW  = DATA_W + 4;
    localparam int PW  = 2 * IW + 1;
    localparam int EW  = $clog2(DATA_W / 2 + 1);
    // Output scaling: product carries DATA_W+IW fraction bits, result wants FRAC_W/2+e of them.
    localparam int RS0 = DATA_W + IW - FRAC_W / 2;

    // Shift index executed by iteration stage a (0-based); 4, 13 and 40 occur twice.
    function automatic int idx_f(input int a);
        int n, r;
        n = 0;
        r = ITER;
        for (int b = 1; b <= ITER; b++) begin
            if (n == a) r = b;
            n++;
            if (b == 4 || b == 13 || b == 40) begin
                if (n == a) r = b;
                n++;
            end
        end
        return r;
    endfunction

    // 1/A_n for the exact iteration sequence; the square root comes from Newton steps.
    function automatic real kinv_f();
        real p, g, d;
        p = 1.0;
        for (int a = 0; a < NST; a++) begin
            d = 1.0;
            for (int c = 0; c < idx_f(a); c++) d = d / 4.0;
            p = p * (1.0 - d);
        end
        g = 1.0;
        for (int c = 0; c < 60; c++) g = 0.5 * (g + 1.0 / (p * g));
        return g;
    endfunction

    localparam longint KQ = longint'(kinv_f() * (2.0 ** IW));
    localparam logic [IW:0] KINV = KQ[IW:0];
    localparam logic [IW-1:0] QUARTER = IW'(1) << (DATA_W - 2);

    logic                     w_adv;
    logic                     r_s0_v;
    logic [DATA_W-1:0]        r_s0_w;
    logic [TAG_W-1:0]         r_s0_tag;
    logic [NST:0]             r_v;
    logic signed [IW-1:0]     r_x [0:NST];
    logic signed [IW-1:0]     r_y [0:NST-1];
    logic                     r_z [0:NST];
    logic [EW-1:0]            r_e [0:NST];
    logic [TAG_W-1:0]         r_t [0:NST];
    int                       w_p, w_pe;
    logic                     w_z;
    logic [IW-1:0]            w_m, w_x0, w_y0;
    logic [IW-1:0]            w_xpos;
    logic [PW-1:0]            w_prod, w_rnd;
    logic [15:0]              w_rs;
    logic [DATA_W-1:0]        w_res;

    assign w_adv    = out_ready | ~out_valid;
    assign in_ready = w_adv;

    // Normalise: leading one at p, rounded up to even pe, gives m = w*2^s in [0.5,2)
    // with s = FRAC_W-pe; sqrt is later rescaled by 2^(pe/2).
    always_comb begin
        w_p = 0;
        for (int b = 0; b < DATA_W; b++) if (r_s0_w[b]) w_p = b;
        w_pe = w_p + (w_p & 1);
        w_z  = ~|r_s0_w;
        w_m  = IW'(r_s0_w) << (DATA_W - w_pe);
        w_x0 = w_z ? QUARTER : w_m + QUARTER;
        w_y0 = w_z ? '0 : w_m - QUARTER;
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s0_w   <= in_data;
            r_s0_tag <= in_tag;
            r_x[0]   <= w_x0;
            r_y[0]   <= w_y0;
            r_z[0]   <= w_z;
            r_e[0]   <= EW'(w_pe / 2);
            r_t[0]   <= r_s0_tag;
        end
    end

    for (genvar k = 1; k <= NST; k++) begin : g_c
        localparam int SH = idx_f(k - 1);
        always_ff @(posedge clk) begin
            if (w_adv) begin
                r_x[k] <= r_y[k-1][IW-1] ? r_x[k-1] + (r_y[k-1] >>> SH) : r_x[k-1] - (r_y[k-1] >>> SH);
                r_z[k] <= r_z[k-1];
                r_e[k] <= r_e[k-1];
                r_t[k] <= r_t[k-1];
            end
        end
        // The last stage's y is never consumed, so it is not kept.
        if (k < NST) begin : g_y
            always_ff @(posedge clk) begin
                if (w_adv) r_y[k] <= r_y[k-1][IW-1] ? r_y[k-1] + (r_x[k-1] >>> SH) : r_y[k-1] - (r_x[k-1] >>> SH);
            end
        end
    end

    // Finish: gain compensation, rescale by 2^(pe/2), round half-up, saturate.
    assign w_xpos = r_x[NST][IW-1] ? '0 : r_x[NST];
    assign w_prod = PW'(w_xpos) * PW'(KINV);
    assign w_rs   = 16'(RS0) - 16'(r_e[NST]);
    assign w_rnd  = (w_prod + (PW'(1) << (w_rs - 16'd1))) >> w_rs;
    assign w_res  = |w_rnd[PW-1:DATA_W] ? '1 : w_rnd[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_v    <= 1'b0;
            r_v       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_zero  <= 1'b0;
        end else if (w_adv) begin
            r_s0_v    <= in_valid;
            r_v       <= {r_v[NST-1:0], r_s0_v};
            out_valid <= r_v[NST];
            out_data  <= r_z[NST] ? '0 : w_res;
            out_tag   <= r_t[NST];
            out_zero  <= r_z[NST];
        end
    end
endmodule
